// File: rtl/timer_counter_if.sv
// Register bus between the system bridge and the timer: word address, write strobe and data, read data, irq.
// Latency: purely a wiring bundle, adds no delay.
// Backpressure: none; the bus has no handshake and every access completes in one cycle.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  // Bridge side drives the access and observes read data and the interrupt line.
  modport master (output addr, output we, output din, input dout, input irq);
  // Timer side.
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes (auto-reload under TIMER_AUTORELOAD_EN).
// Latency: reads are combinational on addr; writes land on the next rising edge of clk.
// Backpressure: none; every bus write is accepted on the edge it is presented.
module timer_counter #(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // ctrl_q: [0] EN, [2:1] MODE, [3] IM
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  state_t      state_q, state_d;
  logic        ctrl_we;
  logic        preset_we;
  logic        expire;

  assign ctrl_we   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_we = bus.we && (bus.addr == ADDR_PRESET);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus register updates; FSM decisions use pre-edge EN, and a CTRL write overrides the FSM's EN clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    ctrl_d    = ctrl_q;
    expire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          state_d = INT;
          expire  = 1'b1;
        end
      end
      INT: begin
`ifdef TIMER_AUTORELOAD_EN
        if (ctrl_q[2:1] == 2'b01) begin
          pending_d = 1'b0;
          state_d   = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
`else
        ctrl_d[0] = 1'b0;
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (ctrl_we) begin
      ctrl_d    = bus.din[3:0];
      pending_d = 1'b0;
    end
    // Expiry on the same edge as a CTRL write still latches the interrupt.
    if (expire) pending_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 4'd0;
      preset_q  <= RESET_PRESET;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      if (preset_we) preset_q <= bus.din;
    end
  end

  // Read mux; the reserved offset reads zero.
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = {28'd0, ctrl_q};
      ADDR_PRESET: bus.dout = preset_q;
      ADDR_COUNT:  bus.dout = count_q;
      default:     bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = pending_q & ctrl_q[3];

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer on the CPU's external data bus, addressed through the system bridge alongside data memory. It counts down from a programmable preset and raises an interrupt request that the bridge feeds into one `HWInt` bit of CP0. Two modes are supported: one-shot (mode 0) and auto-reload periodic (mode 1).

## Interface
Parameters:
- `RESET_PRESET`, 32'h0000_0000: reset value of PRESET.

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; all registers and FSM to reset values.
- `addr`  in  2  word offset, equal to bus address [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- `we`  in  1  write strobe, already qualified by the bridge's address decode.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request = `pending & CTRL.IM`.

## Operation
- CTRL: [0] EN, [2:1] MODE, [3] IM; bits [31:4] are not stored and read 0. Writing CTRL stores bits [3:0] and clears `pending`.
- PRESET: fully writable. The new value takes effect at the next LOAD; a count already in progress is not affected.
- COUNT: read-only. Writes to offset 2 and offset 3 are ignored. Offset 3 reads 0.
- MODE 00 is one-shot and MODE 01 is auto-reload. MODE 1x behaves as MODE 00.
- FSM states are IDLE, LOAD, CNT and INT. Transitions are evaluated on each edge using register values before that edge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If EN=0, go to IDLE and COUNT holds.
    - Else if COUNT != 0, COUNT <= COUNT-1.
    - Else go to INT and set `pending` <= 1.
  - INT, MODE 00: EN <= 0 and go to IDLE. `pending` stays 1 until a CTRL write or reset.
  - INT, MODE 01: `pending` <= 0 and go to LOAD.
- A re-enable after a pause always reloads from PRESET, because the path is IDLE to LOAD.
- Arithmetic is 32-bit unsigned. COUNT never wraps below 0.
- PRESET=0 is legal: CNT is entered with COUNT=0 and goes straight to INT.
- Simultaneous events:
  - If a CTRL write lands on the same edge as the INT-state EN clear, the written value wins. That write also clears `pending`.
  - If a CTRL write lands on the same edge as the CNT-to-INT transition, `pending` ends at 1 and the write still updates EN, MODE and IM.
  - FSM decisions on an edge use the EN value from before that edge. A write takes effect on the following edge.
- Reset values:
  - CTRL=0, PRESET=`RESET_PRESET`, COUNT=0.
  - State=IDLE, `pending`=0.
  - `irq`=0; `dout` reflects the reset registers.
- Reset mid-count aborts the count immediately; no interrupt is produced.

## Timing
- Define e0 as the edge that writes CTRL.EN=1 with preset P:
  - e1: state LOAD.
  - e2: COUNT=P, state CNT.
  - e(2+P): COUNT=0.
  - e(3+P): state INT, `irq` goes high if IM=1.
- One-shot: `irq` stays high from e(3+P) until a CTRL write.
- Auto-reload: `irq` is exactly 1 cycle wide. Period is P+3 cycles.
- `dout` has zero latency, combinational on `addr`. Write latency is 1 edge.
- IM is a pure output mask and does not affect `pending`. Setting IM after expiry raises `irq` combinationally.

## Configuration
- `TIMER_AUTORELOAD_EN`
  - Defined: MODE 01 behaves as described, with INT returning to LOAD.
  - Undefined:
    - Auto-reload logic is removed; all MODE values behave as MODE 00.
    - CTRL[2:1] still store and read back as written.

## Test plan
- Reset, then read offsets 0/1/2/3: expect 0, `RESET_PRESET`, 0, 0, and `irq`=0.
- PRESET=3, CTRL=0x9 (EN, mode0, IM):
  - COUNT reads 3,2,1,0 on e2..e5 and `irq` rises at e6 and holds.
  - CTRL reads 0x8 after e7.
  - A CTRL write of 0 drops `irq` at the next edge.
- PRESET=3, CTRL=0xB (mode1):
  - `irq` is 1-cycle pulses at e6, e12 and e18, with COUNT reloaded to 3 at e8.
  - Without `TIMER_AUTORELOAD_EN`: a single latched `irq` at e6 and no reload.
- PRESET=10, enable, then write CTRL=0x8 at e5:
  - COUNT holds at 7 and no `irq`.
  - Writing CTRL=0x9 again reloads COUNT=10 two edges later.
- PRESET=5, CTRL=0x1 (IM=0):
  - `irq` stays 0 after expiry.
  - Writing CTRL=0x8 (IM=1, EN=0) clears `pending`, so `irq` remains 0.
  - Separately, PRESET=0 with CTRL=0x9 gives `irq` at e3.
- Assert `reset` at e4 during a PRESET=8 count:
  - All registers return to their reset values on that edge and `irq` never asserts.
  - Writes to COUNT are ignored throughout.
